adder_pipe_scan: RTL and testbench

Parametrised pipelined adder with full-scan registers. It is the next generation of the team's registered 4-bit scan adder. Adds `WIDTH`-bit operands plus carry-in across `STAGES` carry-chained pipeline slices, with a valid-tagged stream at one result per cycle. Every flop sits on a single mux-D scan chain for DFT.

---
 rtl/adder_pipe_scan.sv | 113 +++++++++++
 tb/tb_adder_pipe_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_scan.sv
// Pipelined carry-chained adder whose stage registers form one mux-D scan chain.
// Define ADDER_PIPE_SCAN_EN to build the scan muxes; otherwise scan_out is tied to 0.
module adder_pipe_scan #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             CK,
  input  logic             rst_n,
  input  logic             scan_enable,
  input  logic             scan_in,
  input  logic             in_valid,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH:0]   sum,
  output logic             scan_out
);

  localparam int S = WIDTH / STAGES;

  // Stage k occupies v, ps[(k+1)S], c, a[R], b[R] on the chain, with R = WIDTH-(k+1)S.
  function automatic int stage_len(input int k);
    return 2 + (k + 1) * S + 2 * (WIDTH - (k + 1) * S);
  endfunction

  function automatic int stage_base(input int k);
    int acc;
    acc = 0;
    for (int j = 0; j < k; j++) acc += stage_len(j);
    return acc;
  endfunction

  localparam int L  = stage_base(STAGES);
  localparam int LB = stage_base(STAGES - 1);

  logic [L-1:0] chain_q;
  logic [L-1:0] chain_d;
  wire  [L-1:0] func_d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int P = (k + 1) * S;
    localparam int R = WIDTH - P;
    localparam int B = stage_base(k);

    logic         in_v;
    logic         c_in;
    logic [S-1:0] a_sl;
    logic [S-1:0] b_sl;
    logic [S:0]   slice;
    logic [P-1:0] ps_new;

    if (k == 0) begin : g_first
      assign in_v   = in_valid;
      assign c_in   = cin;
      assign a_sl   = a[S-1:0];
      assign b_sl   = b[S-1:0];
      assign ps_new = slice[S-1:0];
      if (R > 0) begin : g_ops
        assign func_d[B+2+P +: R]   = in_v ? a[WIDTH-1:P] : chain_q[B+2+P +: R];
        assign func_d[B+2+P+R +: R] = in_v ? b[WIDTH-1:P] : chain_q[B+2+P+R +: R];
      end
    end else begin : g_next
      localparam int PB = stage_base(k - 1);
      localparam int PP = k * S;
      localparam int PR = WIDTH - PP;
      assign in_v   = chain_q[PB];
      assign c_in   = chain_q[PB+1+PP];
      assign a_sl   = chain_q[PB+2+PP +: S];
      assign b_sl   = chain_q[PB+2+PP+PR +: S];
      assign ps_new = {slice[S-1:0], chain_q[PB+1 +: PP]};
      if (R > 0) begin : g_ops
        assign func_d[B+2+P +: R]   = in_v ? chain_q[PB+2+PP+S +: R]    : chain_q[B+2+P +: R];
        assign func_d[B+2+P+R +: R] = in_v ? chain_q[PB+2+PP+PR+S +: R] : chain_q[B+2+P+R +: R];
      end
    end

    assign slice           = {1'b0, a_sl} + {1'b0, b_sl} + {{S{1'b0}}, c_in};
    assign func_d[B]       = in_v;
    assign func_d[B+1 +: P] = in_v ? ps_new : chain_q[B+1 +: P];
    assign func_d[B+1+P]   = in_v ? slice[S] : chain_q[B+1+P];
  end

`ifdef ADDER_PIPE_SCAN_EN
  always_comb begin
    // NOTE: chain_d gets a value on every path, so no latch can be inferred.
    chain_d = func_d;
    if (scan_enable) chain_d = {chain_q[L-2:0], scan_in};
  end

  assign scan_out = chain_q[L-1];
`else
  logic scan_unused;

  always_comb begin
    chain_d = func_d;
  end

  assign scan_unused = ^{scan_enable, scan_in};
  assign scan_out    = 1'b0;
`endif

  always_ff @(posedge CK) begin
    // NOTE: reset is synchronous and checked first, so it overrides scan shifting too.
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  // Last stage ps and c are contiguous on the chain, so they read out as one field.
  assign out_valid = chain_q[LB];
  assign sum       = chain_q[LB+1 +: WIDTH+1];

endmodule

// File: tb/tb_adder_pipe_scan.sv
// Directed bench for adder_pipe_scan: scoreboard of expected sums, immediate-assert checks.
// Scan-chain steps are compiled only when ADDER_PIPE_SCAN_EN is defined.
module tb_adder_pipe_scan;

  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int L      = 14;

  logic             CK;
  logic             rst_n;
  logic             scan_enable;
  logic             scan_in;
  logic             in_valid;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH:0]   sum;
  logic             scan_out;

  int n_tests;
  int n_fail;
  int n_valid;
  bit mon_en;
  logic [WIDTH:0] exp_q[$];
  logic           bit_q[$];

  adder_pipe_scan #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .CK          (CK),
    .rst_n       (rst_n),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .in_valid    (in_valid),
    .cin         (cin),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .sum         (sum),
    .scan_out    (scan_out)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic cv);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
    if (v) exp_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
  endtask

  task automatic drive_idle();
    drive(1'b0, WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
  endtask

  // One clock edge, then sample 1 time unit later and score any valid result.
  task automatic tick();
    logic [WIDTH:0] e;
    @(posedge CK);
    #1;
    if (mon_en && out_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) check("spurious_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sum_sb", sum, e);
      end
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    scan_enable = 1'($urandom_range(0, 1));
    scan_in     = 1'($urandom_range(0, 1));
    in_valid    = 1'($urandom_range(0, 1));
    a           = WIDTH'($urandom_range(0, 15));
    b           = WIDTH'($urandom_range(0, 15));
    cin         = 1'($urandom_range(0, 1));
    exp_q.delete();
    tick();
    tick();
    rst_n       = 1'b1;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    drive_idle();
  endtask

  initial begin
    int v0;
    logic [L-1:0] pat;
    logic [L-1:0] tgt;
    logic         eb;
    n_tests = 0;
    n_fail  = 0;
    n_valid = 0;
    mon_en  = 1'b0;

    // Reset with random inputs.
    do_reset();
    check("rst_sum", sum, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_scan_out", scan_out, 0);
    mon_en = 1'b1;

    // Single add: 9 + 7 + 0, result one cycle after the accepting edge.
    drive(1'b1, 4'd9, 4'd7, 1'b0);
    tick();
    check("lat_early", out_valid, 0);
    drive_idle();
    v0 = n_valid;
    tick();
    check("single_valid", out_valid, 1);
    check("single_sum", sum, 16);
    tick();
    check("single_drop", out_valid, 0);
    check("single_hold", sum, 16);

    // Back-to-back stream.
    v0 = n_valid;
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    tick();
    drive(1'b1, 4'd8, 4'd8, 1'b0);
    tick();
    drive_idle();
    tick();
    tick();
    tick();
    check("stream_pulses", n_valid - v0, 3);
    check("stream_drained", exp_q.size(), 0);
    check("stream_hold", sum, 16);

    // Reset mid-operation discards the in-flight result.
    drive(1'b1, 4'd5, 4'd6, 1'b0);
    tick();
    rst_n = 1'b0;
    drive_idle();
    exp_q.delete();
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("midrst_after_valid", out_valid, 0);
    check("midrst_after_sum", sum, 0);

    // Random stream with gaps.
    v0 = n_valid;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive(1'b1, WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      else
        drive_idle();
      tick();
    end
    drive_idle();
    tick();
    tick();
    check("rand_drained", exp_q.size(), 0);

`ifdef ADDER_PIPE_SCAN_EN
    // Shift a pattern through the whole chain.
    mon_en = 1'b0;
    do_reset();
    pat = 14'b10110011100101;
    scan_enable = 1'b1;
    for (int i = 0; i < 2 * L; i++) begin
      scan_in = (i < L) ? pat[L-1-i] : 1'b0;
      bit_q.push_back(scan_in);
      in_valid = 1'($urandom_range(0, 1));
      a        = WIDTH'($urandom_range(0, 15));
      tick();
      if (i >= L - 1) begin
        eb = bit_q.pop_front();
        check("scan_shift", scan_out, eb);
      end else begin
        check("scan_pre", scan_out, 0);
      end
    end
    bit_q.delete();

    // Load a state: stage0 v=1 ps=01 c=1 a=10 b=11; stage1 v=1 ps=A c=1.
    do_reset();
    tgt = '0;
    tgt[0]    = 1'b1;
    tgt[2:1]  = 2'b01;
    tgt[3]    = 1'b1;
    tgt[5:4]  = 2'b10;
    tgt[7:6]  = 2'b11;
    tgt[8]    = 1'b1;
    tgt[12:9] = 4'hA;
    tgt[13]   = 1'b1;
    scan_enable = 1'b1;
    for (int i = L - 1; i >= 0; i--) begin
      scan_in = tgt[i];
      tick();
    end
    scan_enable = 1'b0;
    drive_idle();
    check("cap_valid", out_valid, 1);
    check("cap_sum", sum, 26);
    check("cap_scan_out", scan_out, 1);
    tick();
    check("cap_next_valid", out_valid, 1);
    check("cap_next_sum", sum, 25);
    tick();
    check("cap_end_valid", out_valid, 0);
    check("cap_end_sum", sum, 25);
    mon_en = 1'b1;
`else
    // Without the scan build, scan inputs must not disturb the datapath.
    scan_enable = 1'b1;
    scan_in     = 1'b1;
    drive(1'b1, 4'd3, 4'd12, 1'b1);
    tick();
    drive_idle();
    tick();
    check("noscan_valid", out_valid, 1);
    check("noscan_sum", sum, 16);
    check("noscan_scan_out", scan_out, 0);
    scan_enable = 1'b0;
    scan_in     = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
